ras_ckpt: RTL
=============

Name: ras_ckpt

Overview:
- Parametrised successor to the fixed two-entry return-address stack in the frontend branch-prediction unit.
- Circular RAS of configurable depth; RASDepth and VLEN are taken from the cva6 config.
- Adds single-checkpoint save/restore so a mispredicted branch can roll back speculative pushes and pops.
- Adds overflow wrap (oldest entry overwritten) and underflow reporting.
- Sits between the instruction-scan stage (push/pop) and the frontend redirect logic (checkpoint, restore, flush).

Parameters:
- DEPTH, 2, number of RAS entries; legal range 2..64, power of two not required.
- VLEN, 32, virtual-address width of each return address.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  empty stack and invalidate checkpoint
- push_i  in  1  push call return address
- pop_i  in  1  pop on return
- data_i  in  VLEN  address to push
- ckpt_save_i  in  1  capture checkpoint (pointer, count, top entry)
- ckpt_restore_i  in  1  roll back to checkpoint
- top_valid_o  out  1  stack non-empty
- top_o  out  VLEN  current top-of-stack address (combinational from state)
- count_o  out  $clog2(DEPTH+1)  valid entries
- ckpt_valid_o  out  1  checkpoint held
- underflow_o  out  1  pulse: pop on empty, registered
- overflow_cnt_o  out  16  saturating overflow count (see optional feature)
- underflow_cnt_o  out  16  saturating underflow count (see optional feature)

Behaviour:
State and reset:
- State: entry array, top pointer tos (0..DEPTH-1), count (0..DEPTH), checkpoint {ptr, count, entry, valid}.
- On rst_ni low: tos=DEPTH-1, count=0, all entries 0, checkpoint cleared.
- On rst_ni low, all outputs 0: top_valid_o, top_o, count_o, ckpt_valid_o, underflow_o, counters.

Top-of-stack outputs:
- top_o = entry[tos] whenever count>0, else 0.
- top_valid_o = (count != 0).
- All updates become visible the cycle after the request.

Priority, highest first: flush_i > ckpt_restore_i > push_i/pop_i. Save is evaluated alongside push/pop.

Stack operations (tos wraps explicitly: DEPTH-1 -> 0 on increment, 0 -> DEPTH-1 on decrement):
- push only:
  - tos=tos+1 wrapped; entry[new tos]=data_i.
  - count=min(count+1, DEPTH).
  - Push at count==DEPTH overwrites the oldest entry; count stays DEPTH.
- pop only:
  - If count>0: tos=tos-1 wrapped, count-1; the entry is not cleared.
  - If count==0: no state change; underflow_o=1 for one cycle.
- push and pop together: entry[tos]=data_i; tos and count unchanged.
  - On an empty stack this becomes a push (count becomes 1); no underflow is flagged.

Checkpoint:
- ckpt_save_i stores the pre-update {tos, count, entry[tos]} and sets ckpt_valid. A save in the same cycle as push/pop captures state before that op.
- ckpt_restore_i with a valid checkpoint:
  - tos=ckpt.ptr, count=ckpt.count, entry[ckpt.ptr]=ckpt.entry.
  - ckpt_valid cleared; same-cycle push/pop/save ignored.
- ckpt_restore_i without a valid checkpoint: stack emptied (count=0, tos unchanged).
- Restore only repairs the top entry. Deeper entries overwritten by speculative overflow pushes are not recovered; this is accepted predictor inaccuracy.

Flush:
- flush_i sets count=0, ckpt_valid=0.
- Entries and tos are untouched; all other inputs are ignored that cycle.

Widths:
- tos width max(1, $clog2(DEPTH)).
- All pointer arithmetic uses explicit compare-and-wrap, never modulo.

Optional Feature:
RAS_PERF_CNT_EN
- Defined:
  - overflow_cnt_o increments on each push-only at count==DEPTH.
  - underflow_cnt_o increments on each underflow_o pulse.
  - Both are 16-bit, saturate at 16'hFFFF, are cleared only by reset (flush does not clear them), and update one cycle after the event.
- Undefined: both outputs are tied to 0 and no counter flops are generated.

Test Plan:
- DEPTH=2: push 0x100, push 0x200 -> count_o=2, top_o=0x200; pop, pop -> top_o=0x100 then top_valid_o=0; third pop -> underflow_o=1 for one cycle, count_o=0.
- DEPTH=2: push 0xA, 0xB, 0xC -> count_o=2, top_o=0xC; pop -> top_o=0xB; pop -> empty (0xA was lost); with RAS_PERF_CNT_EN, overflow_cnt_o=1.
- Push 0x40, then push+pop with data 0x80 in the same cycle -> count_o=1, top_o=0x80; push+pop on an empty stack with 0x90 -> count_o=1, top_o=0x90, no underflow.
- DEPTH=4: push 0x10, 0x20; save; pop; push 0x30, 0x34; restore -> count_o=2, top_o=0x20, ckpt_valid_o=0; restore again -> count_o=0.
- Save with push 0x50 in the same cycle from count=1 (top 0x10) -> a later restore gives count_o=1, top_o=0x10; flush asserted together with restore -> count_o=0, ckpt_valid_o=0.
- With RAS_PERF_CNT_EN, issue 70000 pops on an empty stack -> underflow_cnt_o saturates at 0xFFFF; assert rst_ni low mid-sequence -> every output reads 0 in that same cycle.

Source files
------------

// File: rtl/ras_ckpt.sv
// ras_ckpt: circular return-address stack with a single checkpoint for
// rolling back speculative pushes/pops after a branch mispredict.
// Optional build macro RAS_PERF_CNT_EN adds saturating overflow/underflow
// event counters; without it both counter outputs are tied to zero.
module ras_ckpt #(
  parameter int DEPTH = 2,
  parameter int VLEN  = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [VLEN-1:0]              data_i,
  input  logic                         ckpt_save_i,
  input  logic                         ckpt_restore_i,
  output logic                         top_valid_o,
  output logic [VLEN-1:0]              top_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         ckpt_valid_o,
  output logic                         underflow_o,
  output logic [15:0]                  overflow_cnt_o,
  output logic [15:0]                  underflow_cnt_o
);

  localparam int PW = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH-1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [VLEN-1:0] entry_q [DEPTH];
  logic [PW-1:0]   tos_q, tos_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            uf_q, uf_d;

  logic [PW-1:0]   ck_ptr_q, ck_ptr_d;
  logic [CW-1:0]   ck_cnt_q, ck_cnt_d;
  logic [VLEN-1:0] ck_entry_q, ck_entry_d;
  logic            ck_valid_q, ck_valid_d;

  logic            wr_en;
  logic [PW-1:0]   wr_ptr;
  logic [VLEN-1:0] wr_data;

  logic [PW-1:0]   tos_inc, tos_dec;

  // Explicit compare-and-wrap so non-power-of-two depths stay in range.
  assign tos_inc = (tos_q == LAST)     ? '0   : tos_q + PW'(1);
  assign tos_dec = (tos_q == PW'(0))   ? LAST : tos_q - PW'(1);

  assign top_valid_o  = (cnt_q != '0);
  assign top_o        = top_valid_o ? entry_q[tos_q] : '0;
  assign count_o      = cnt_q;
  assign ckpt_valid_o = ck_valid_q;
  assign underflow_o  = uf_q;

  // Next-state: flush beats restore beats push/pop; save rides along with push/pop.
  always_comb begin
    tos_d      = tos_q;
    cnt_d      = cnt_q;
    uf_d       = 1'b0;
    wr_en      = 1'b0;
    wr_ptr     = tos_q;
    wr_data    = data_i;
    ck_ptr_d   = ck_ptr_q;
    ck_cnt_d   = ck_cnt_q;
    ck_entry_d = ck_entry_q;
    ck_valid_d = ck_valid_q;

    if (flush_i) begin
      cnt_d      = '0;
      ck_valid_d = 1'b0;
    end else if (ckpt_restore_i) begin
      if (ck_valid_q) begin
        // Only the top entry is repaired; deeper overwrites stay lost.
        tos_d      = ck_ptr_q;
        cnt_d      = ck_cnt_q;
        wr_en      = 1'b1;
        wr_ptr     = ck_ptr_q;
        wr_data    = ck_entry_q;
        ck_valid_d = 1'b0;
      end else begin
        cnt_d = '0;
      end
    end else begin
      if (ckpt_save_i) begin
        ck_ptr_d   = tos_q;
        ck_cnt_d   = cnt_q;
        ck_entry_d = entry_q[tos_q];
        ck_valid_d = 1'b1;
      end
      if (push_i && (!pop_i || cnt_q == '0)) begin
        // Plain push (or push+pop on empty): full stack overwrites the oldest.
        tos_d  = tos_inc;
        wr_en  = 1'b1;
        wr_ptr = tos_inc;
        if (cnt_q != FULL) begin
          cnt_d = cnt_q + CW'(1);
        end
      end else if (push_i && pop_i) begin
        // Return followed by call: replace top in place.
        wr_en = 1'b1;
      end else if (pop_i) begin
        if (cnt_q != '0) begin
          tos_d = tos_dec;
          cnt_d = cnt_q - CW'(1);
        end else begin
          uf_d = 1'b1;
        end
      end
    end
  end

  // Pointer, count, underflow pulse and checkpoint registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tos_q      <= LAST;
      cnt_q      <= '0;
      uf_q       <= 1'b0;
      ck_ptr_q   <= '0;
      ck_cnt_q   <= '0;
      ck_entry_q <= '0;
      ck_valid_q <= 1'b0;
    end else begin
      tos_q      <= tos_d;
      cnt_q      <= cnt_d;
      uf_q       <= uf_d;
      ck_ptr_q   <= ck_ptr_d;
      ck_cnt_q   <= ck_cnt_d;
      ck_entry_q <= ck_entry_d;
      ck_valid_q <= ck_valid_d;
    end
  end

  // Entry array: single write port, cleared on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else if (wr_en) begin
      entry_q[wr_ptr] <= wr_data;
    end
  end

`ifdef RAS_PERF_CNT_EN
  logic        ovf_evt;
  logic [15:0] ovf_cnt_q, uf_cnt_q;

  assign ovf_evt = !flush_i && !ckpt_restore_i && push_i && !pop_i && (cnt_q == FULL);

  // Saturating event counters; only reset clears them, flush does not.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_cnt_q <= '0;
      uf_cnt_q  <= '0;
    end else begin
      if (ovf_evt && ovf_cnt_q != 16'hFFFF) begin
        ovf_cnt_q <= ovf_cnt_q + 16'd1;
      end
      if (uf_d && uf_cnt_q != 16'hFFFF) begin
        uf_cnt_q <= uf_cnt_q + 16'd1;
      end
    end
  end

  assign overflow_cnt_o  = ovf_cnt_q;
  assign underflow_cnt_o = uf_cnt_q;
`else
  assign overflow_cnt_o  = '0;
  assign underflow_cnt_o = '0;
`endif

endmodule
